// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared definitions for the iterative multiply/divide unit.
//   - EXE_* : ALU execute-command codes used by the shared codebase ALU
//   - op_e  : operation select encodings (MULTU / DIVU)
//   - state_e: FSM state encodings for the mul/div sequencer
package mul_div_unit_pkg;

  localparam logic [3:0] EXE_ADD = 4'h0;
  localparam logic [3:0] EXE_SUB = 4'h1;
  localparam logic [3:0] EXE_AND = 4'h2;
  localparam logic [3:0] EXE_OR  = 4'h3;
  localparam logic [3:0] EXE_XOR = 4'h4;

  typedef enum logic {
    OP_MULTU = 1'b0,
    OP_DIVU  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/response bundle for mul_div_unit.
//   master (requester): drives start, op, val1, val2, flush;
//                       observes busy, done, hi, lo, div_zero.
//   slave  (mul_div_unit): the mirror image.
interface mul_div_unit_if #(
  parameter int SIZE = 32
);
  logic            start;
  logic            op;
  logic [SIZE-1:0] val1;
  logic [SIZE-1:0] val2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] hi;
  logic [SIZE-1:0] lo;
  logic            div_zero;

  modport master (
    output start, op, val1, val2, flush,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, val1, val2, flush,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/mul_div_unit_alu.sv
// mul_div_unit_alu: codebase integer ALU, combinational.
// Ports:
//   cmd   : execute command (EXE_ADD / EXE_SUB / EXE_AND / EXE_OR / EXE_XOR)
//   a, b  : operands
//   y     : result
//   carry : carry-out for ADD; for SUB it is the no-borrow flag (a >= b)
module mul_div_unit_alu
  import mul_div_unit_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int COM_SIZE = 4
) (
  input  logic [COM_SIZE-1:0] cmd,
  input  logic [SIZE-1:0]     a,
  input  logic [SIZE-1:0]     b,
  output logic [SIZE-1:0]     y,
  output logic                carry
);

  localparam logic [COM_SIZE-1:0] CMD_ADD = COM_SIZE'(EXE_ADD);
  localparam logic [COM_SIZE-1:0] CMD_SUB = COM_SIZE'(EXE_SUB);
  localparam logic [COM_SIZE-1:0] CMD_AND = COM_SIZE'(EXE_AND);
  localparam logic [COM_SIZE-1:0] CMD_OR  = COM_SIZE'(EXE_OR);
  localparam logic [COM_SIZE-1:0] CMD_XOR = COM_SIZE'(EXE_XOR);

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (cmd)
      CMD_ADD: {carry, y} = {1'b0, a} + {1'b0, b};
      // Two's-complement subtract: carry out of a + ~b + 1 means no borrow.
      CMD_SUB: {carry, y} = {1'b0, a} + {1'b0, ~b} + (SIZE+1)'(1);
      CMD_AND: y = a & b;
      CMD_OR:  y = a | b;
      CMD_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned multiply (shift-add) / divide (restoring),
// one result bit per cycle, SIZE cycles per operation.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mul_div_unit_if.slave
//          start/op/val1/val2 request an operation (sampled in IDLE only),
//          flush aborts to IDLE, busy = iterating, done = 1-cycle completion,
//          hi/lo = product words or remainder/quotient, div_zero = DIVU by 0.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int COM_SIZE = 4
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(SIZE) + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  // Multiplicand (MULTU) or divisor (DIVU).
  logic [SIZE-1:0]   opnd_q, opnd_d;
  // Accumulator (MULTU high word) or partial remainder (DIVU).
  logic [SIZE-1:0]   acc_q, acc_d;
  // Multiplier shifting into low product (MULTU) or dividend shifting into quotient (DIVU).
  logic [SIZE-1:0]   work_q, work_d;
  logic [SIZE-1:0]   hi_q, hi_d;
  logic [SIZE-1:0]   lo_q, lo_d;
  logic              dz_q, dz_d;

  logic [COM_SIZE-1:0] alu_cmd;
  logic [SIZE-1:0]     alu_a;
  logic [SIZE-1:0]     alu_y;
  logic                alu_carry;

  logic [SIZE:0]       shifted;
  logic                ge;
  logic [SIZE:0]       sum;
  logic [SIZE-1:0]     step_acc;
  logic [SIZE-1:0]     step_work;

  mul_div_unit_alu #(
    .SIZE     (SIZE),
    .COM_SIZE (COM_SIZE)
  ) u_alu (
    .cmd   (alu_cmd),
    .a     (alu_a),
    .b     (opnd_q),
    .y     (alu_y),
    .carry (alu_carry)
  );

  // One iteration step of whichever operation is latched.
  always_comb begin
    shifted   = {acc_q, work_q[SIZE-1]};
    ge        = (shifted >= {1'b0, opnd_q});
    alu_cmd   = COM_SIZE'(EXE_ADD);
    alu_a     = acc_q;
    sum       = '0;
    step_acc  = acc_q;
    step_work = work_q;
    if (op_q == OP_DIVU) begin
      alu_cmd   = COM_SIZE'(EXE_SUB);
      alu_a     = shifted[SIZE-1:0];
      // When ge holds, shifted < 2*divisor, so the difference fits in SIZE bits.
      step_acc  = ge ? alu_y : shifted[SIZE-1:0];
      step_work = {work_q[SIZE-2:0], ge};
    end else begin
      sum       = work_q[0] ? {alu_carry, alu_y} : {1'b0, acc_q};
      step_acc  = sum[SIZE:1];
      step_work = {sum[0], work_q[SIZE-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    work_d  = work_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_d   = op_e'(bus.op);
            opnd_d = bus.op ? bus.val2 : bus.val1;
            work_d = bus.op ? bus.val1 : bus.val2;
            acc_d  = '0;
            cnt_d  = '0;
            dz_d   = 1'b0;
            if (bus.op && (bus.val2 == '0)) begin
              state_d = ST_DONE;
              hi_d    = bus.val1;
              lo_d    = '1;
              dz_d    = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc_d  = step_acc;
          work_d = step_work;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SIZE - 1)) begin
            state_d = ST_DONE;
            hi_d    = step_acc;
            lo_d    = step_work;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULTU;
      opnd_q  <= '0;
      acc_q   <= '0;
      work_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      work_q  <= work_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

  localparam int SIZE = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mul_div_unit_if #(.SIZE(SIZE)) bus ();

  mul_div_unit #(
    .SIZE     (SIZE),
    .COM_SIZE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (edge N); returns #1 after edge N.
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.val1  = a;
    bus.val2  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Waits for done; done_k = edges after the call point at which done is seen.
  task automatic wait_done(output int busy_cnt, output int done_k);
    busy_cnt = 0;
    done_k   = -1;
    for (int k = 0; k < 100; k++) begin
      if (bus.done) begin
        done_k = k;
        break;
      end
      if (bus.busy) busy_cnt++;
      tick();
    end
    if (done_k < 0) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  int busy_cnt;
  int done_k;
  int done_seen;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 1'b0;
    bus.val1   = '0;
    bus.val2   = '0;
    bus.flush  = 1'b0;
    #22;
    check_eq("reset_busy", 64'(bus.busy), 64'd0);
    check_eq("reset_done", 64'(bus.done), 64'd0);
    check_eq("reset_hi",   64'(bus.hi),   64'd0);
    check_eq("reset_lo",   64'(bus.lo),   64'd0);
    check_eq("reset_dz",   64'(bus.div_zero), 64'd0);
    rst = 1'b0;
    tick();

    // MULTU 7 x 6
    issue(1'b0, 32'd7, 32'd6);
    wait_done(busy_cnt, done_k);
    check_eq("mul7x6_busy_cycles", 64'(busy_cnt), 64'd32);
    check_eq("mul7x6_done_edge",   64'(done_k),   64'd32);
    check_eq("mul7x6_hi", 64'(bus.hi), 64'd0);
    check_eq("mul7x6_lo", 64'(bus.lo), 64'd42);
    check_eq("mul7x6_dz", 64'(bus.div_zero), 64'd0);
    tick();
    check_eq("mul7x6_done_pulse", 64'(bus.done), 64'd0);

    // MULTU max x max
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(busy_cnt, done_k);
    check_eq("mulmax_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    check_eq("mulmax_lo", 64'(bus.lo), 64'h0000_0001);
    tick();

    // DIVU 100 / 7
    issue(1'b1, 32'd100, 32'd7);
    wait_done(busy_cnt, done_k);
    check_eq("div100_7_busy", 64'(busy_cnt), 64'd32);
    check_eq("div100_7_lo", 64'(bus.lo), 64'd14);
    check_eq("div100_7_hi", 64'(bus.hi), 64'd2);
    check_eq("div100_7_dz", 64'(bus.div_zero), 64'd0);
    tick();

    // DIVU 5 / 0
    issue(1'b1, 32'd5, 32'd0);
    wait_done(busy_cnt, done_k);
    check_eq("div0_done_edge", 64'(done_k), 64'd0);
    check_eq("div0_busy", 64'(busy_cnt), 64'd0);
    check_eq("div0_hi", 64'(bus.hi), 64'd5);
    check_eq("div0_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    check_eq("div0_dz", 64'(bus.div_zero), 64'd1);
    tick();
    check_eq("div0_done_pulse", 64'(bus.done), 64'd0);
    check_eq("div0_dz_held", 64'(bus.div_zero), 64'd1);

    // Next accepted start clears div_zero
    issue(1'b1, 32'hFFFF_FFFF, 32'h10);
    check_eq("dz_cleared_on_start", 64'(bus.div_zero), 64'd0);
    wait_done(busy_cnt, done_k);
    check_eq("divbig_lo", 64'(bus.lo), 64'h0FFF_FFFF);
    check_eq("divbig_hi", 64'(bus.hi), 64'hF);
    tick();

    issue(1'b0, 32'd1234, 32'd5678);
    wait_done(busy_cnt, done_k);
    check_eq("mul1234_lo", 64'(bus.lo), 64'd7006652);
    check_eq("mul1234_hi", 64'(bus.hi), 64'd0);
    tick();

    // Flush mid-RUN
    prev_hi = 32'd0;
    prev_lo = 32'd7006652;
    issue(1'b0, 32'd3, 32'd3);
    repeat (9) tick();
    check_eq("flush_pre_busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_eq("flush_busy", 64'(bus.busy), 64'd0);
    check_eq("flush_done", 64'(bus.done), 64'd0);
    check_eq("flush_hi_kept", 64'(bus.hi), 64'(prev_hi));
    check_eq("flush_lo_kept", 64'(bus.lo), 64'(prev_lo));
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done || bus.busy) done_seen++;
      tick();
    end
    check_eq("flush_no_done", 64'(done_seen), 64'd0);
    issue(1'b0, 32'd3, 32'd3);
    wait_done(busy_cnt, done_k);
    check_eq("after_flush_lo", 64'(bus.lo), 64'd9);
    check_eq("after_flush_busy", 64'(busy_cnt), 64'd32);
    tick();

    // start during RUN is ignored
    issue(1'b0, 32'd7, 32'd6);
    repeat (5) tick();
    issue(1'b1, 32'd100, 32'd100);
    wait_done(busy_cnt, done_k);
    check_eq("midstart_done_edge", 64'(done_k), 64'd26);
    check_eq("midstart_lo", 64'(bus.lo), 64'd42);
    check_eq("midstart_hi", 64'(bus.hi), 64'd0);
    tick();

    // start + flush together in IDLE
    bus.flush = 1'b1;
    issue(1'b1, 32'd50, 32'd5);
    bus.flush = 1'b0;
    check_eq("startflush_busy", 64'(bus.busy), 64'd0);
    check_eq("startflush_done", 64'(bus.done), 64'd0);
    tick();
    check_eq("startflush_busy2", 64'(bus.busy), 64'd0);
    check_eq("startflush_lo_kept", 64'(bus.lo), 64'd42);

    // Async reset mid-RUN
    issue(1'b0, 32'd7, 32'd6);
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", 64'(bus.busy), 64'd0);
    check_eq("arst_done", 64'(bus.done), 64'd0);
    check_eq("arst_hi",   64'(bus.hi),   64'd0);
    check_eq("arst_lo",   64'(bus.lo),   64'd0);
    check_eq("arst_dz",   64'(bus.div_zero), 64'd0);
    #1;
    rst = 1'b0;
    issue(1'b1, 32'd9, 32'd3);
    check_eq("post_rst_accept", 64'(bus.busy), 64'd1);
    wait_done(busy_cnt, done_k);
    check_eq("div9_3_lo", 64'(bus.lo), 64'd3);
    check_eq("div9_3_hi", 64'(bus.hi), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
